// File: rtl/stack_pkg.sv
// Shared constants and types for the parameterised LIFO stack.
// Overflow policy codes and the per-cycle operation decode.
package stack_pkg;

    localparam int OVF_REJECT = 0;
    localparam int OVF_WRAP   = 1;

    typedef enum logic [2:0] {
        OP_NONE,
        OP_FLUSH,
        OP_PUSH,
        OP_POP,
        OP_SWAP
    } stack_op_t;

endpackage

// File: rtl/stack_regfile.sv
// Stack storage: DEPTH x WIDTH array, one synchronous write port
// and one asynchronous read port. Contents are never reset.
module stack_regfile
    import stack_pkg::*;
#(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/param_stack.sv
// Parameterised LIFO stack with sticky overflow/underflow flags
// and a selectable reject/overwrite-oldest policy when full.
module param_stack
    import stack_pkg::*;
#(
    parameter int WIDTH    = 12,
    parameter int DEPTH    = 8,
    parameter int OVF_MODE = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full,
    output logic                       ovf_err,
    output logic                       unf_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [AW-1:0] TOP_RST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

    stack_op_t     op;
    logic [AW-1:0] top, top_nxt, top_inc, waddr;
    logic [CW-1:0] cnt_nxt;
    logic          we, set_ovf, set_unf, clr_err;
    logic [WIDTH-1:0] rf_rdata;

    assign top_inc = top + AW'(1);
    assign empty   = (count == '0);
    assign full    = (count == CNT_MAX);
    assign rdata   = empty ? '0 : rf_rdata;

    always_comb begin
        op = OP_NONE;
        unique case (1'b1)
            flush:                 op = OP_FLUSH;
            !flush && push && pop: op = OP_SWAP;
            !flush && push && !pop: op = OP_PUSH;
            !flush && !push && pop: op = OP_POP;
            default:               op = OP_NONE;
        endcase
    end

    always_comb begin
        we      = 1'b0;
        waddr   = top_inc;
        top_nxt = top;
        cnt_nxt = count;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        clr_err = 1'b0;
        case (op)
            OP_FLUSH: begin
                top_nxt = TOP_RST;
                cnt_nxt = '0;
                clr_err = 1'b1;
            end
            OP_SWAP: begin
                if (empty) begin
                    // Nothing to replace: behaves as a plain push.
                    we      = 1'b1;
                    top_nxt = top_inc;
                    cnt_nxt = count + CW'(1);
                    set_unf = 1'b1;
                end else begin
                    we    = 1'b1;
                    waddr = top;
                end
            end
            OP_PUSH: begin
                if (!full) begin
                    we      = 1'b1;
                    top_nxt = top_inc;
                    cnt_nxt = count + CW'(1);
                end else begin
                    set_ovf = 1'b1;
                    // top+1 wraps onto the oldest entry.
                    if (OVF_MODE == OVF_WRAP) begin
                        we      = 1'b1;
                        top_nxt = top_inc;
                    end
                end
            end
            OP_POP: begin
                if (empty) begin
                    set_unf = 1'b1;
                end else begin
                    top_nxt = top - AW'(1);
                    cnt_nxt = count - CW'(1);
                end
            end
            default: ;
        endcase
        if (rst) begin
            we = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            top     <= TOP_RST;
            count   <= '0;
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            top     <= top_nxt;
            count   <= cnt_nxt;
            ovf_err <= !clr_err && (ovf_err || set_ovf);
            unf_err <= !clr_err && (unf_err || set_unf);
        end
    end

    stack_regfile #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_rf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .raddr (top),
        .rdata (rf_rdata)
    );

endmodule

// File: tb/tb_param_stack.sv
// Directed self-checking bench for param_stack; u0 rejects when full,
// u1 overwrites the oldest entry. Both share the same stimulus.
module tb_param_stack;

    logic        clk;
    logic        rst;
    logic        push;
    logic        pop;
    logic        flush;
    logic [11:0] wdata;
    logic [11:0] rdata0, rdata1;
    logic [3:0]  count0, count1;
    logic        empty0, empty1, full0, full1;
    logic        ovf0, ovf1, unf0, unf1;

    int nchk = 0;
    int nerr = 0;

    param_stack #(.WIDTH(12), .DEPTH(8), .OVF_MODE(0)) u0 (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (wdata),
        .rdata   (rdata0),
        .count   (count0),
        .empty   (empty0),
        .full    (full0),
        .ovf_err (ovf0),
        .unf_err (unf0)
    );

    param_stack #(.WIDTH(12), .DEPTH(8), .OVF_MODE(1)) u1 (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (flush),
        .wdata   (wdata),
        .rdata   (rdata1),
        .count   (count1),
        .empty   (empty1),
        .full    (full1),
        .ovf_err (ovf1),
        .unf_err (unf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic op(input logic p, input logic q, input logic f,
                      input logic [11:0] d);
        push  = p;
        pop   = q;
        flush = f;
        wdata = d;
        @(posedge clk);
        #1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        nchk++;
        if (count0 !== 4'd0) begin
            nerr++;
            $display("FAIL reset_count got %0d exp 0", count0);
        end
        nchk++;
        if (rdata0 !== 12'd0) begin
            nerr++;
            $display("FAIL reset_rdata got %0d exp 0", rdata0);
        end
        nchk++;
        if ({empty0, full0} !== 2'b10) begin
            nerr++;
            $display("FAIL reset_empty_full got %b exp 10", {empty0, full0});
        end
        nchk++;
        if ({ovf0, unf0, ovf1, unf1} !== 4'b0000) begin
            nerr++;
            $display("FAIL reset_flags got %b exp 0000",
                     {ovf0, unf0, ovf1, unf1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        op(1, 0, 0, 12'd1);
        op(1, 0, 0, 12'd2);
        op(1, 0, 0, 12'd3);
        nchk++;
        if (count0 !== 4'd3 || rdata0 !== 12'd3) begin
            nerr++;
            $display("FAIL basic_push got cnt=%0d rd=%0d exp cnt=3 rd=3",
                     count0, rdata0);
        end
        for (int i = 2; i >= 0; i--) begin
            op(0, 1, 0, 12'd0);
            nchk++;
            if (rdata0 !== 12'(i)) begin
                nerr++;
                $display("FAIL basic_pop got %0d exp %0d", rdata0, i);
            end
        end
        nchk++;
        if (empty0 !== 1'b1 || unf0 !== 1'b0) begin
            nerr++;
            $display("FAIL basic_end got empty=%b unf=%b exp empty=1 unf=0",
                     empty0, unf0);
        end
    endtask

    task automatic test_ovf_reject;
        op(0, 0, 1, 12'd0);
        for (int i = 1; i <= 9; i++) op(1, 0, 0, 12'(i));
        nchk++;
        if (full0 !== 1'b1 || count0 !== 4'd8 || rdata0 !== 12'd8
            || ovf0 !== 1'b1) begin
            nerr++;
            $display("FAIL rej_full got f=%b c=%0d r=%0d o=%b exp 1 8 8 1",
                     full0, count0, rdata0, ovf0);
        end
        for (int i = 7; i >= 0; i--) begin
            op(0, 1, 0, 12'd0);
            nchk++;
            if (rdata0 !== 12'(i)) begin
                nerr++;
                $display("FAIL rej_pop got %0d exp %0d", rdata0, i);
            end
        end
        nchk++;
        if (empty0 !== 1'b1 || count0 !== 4'd0) begin
            nerr++;
            $display("FAIL rej_empty got e=%b c=%0d exp e=1 c=0",
                     empty0, count0);
        end
    endtask

    task automatic test_ovf_wrap;
        op(0, 0, 1, 12'd0);
        nchk++;
        if (ovf0 !== 1'b0 || ovf1 !== 1'b0) begin
            nerr++;
            $display("FAIL wrap_flush_ovf got %b%b exp 00", ovf0, ovf1);
        end
        for (int i = 1; i <= 10; i++) op(1, 0, 0, 12'(i));
        nchk++;
        if (count1 !== 4'd8 || rdata1 !== 12'd10 || ovf1 !== 1'b1
            || full1 !== 1'b1) begin
            nerr++;
            $display("FAIL wrap_full got c=%0d r=%0d o=%b f=%b exp 8 10 1 1",
                     count1, rdata1, ovf1, full1);
        end
        for (int i = 9; i >= 3; i--) begin
            op(0, 1, 0, 12'd0);
            nchk++;
            if (rdata1 !== 12'(i)) begin
                nerr++;
                $display("FAIL wrap_pop got %0d exp %0d", rdata1, i);
            end
        end
        op(0, 1, 0, 12'd0);
        nchk++;
        if (empty1 !== 1'b1 || rdata1 !== 12'd0) begin
            nerr++;
            $display("FAIL wrap_empty got e=%b r=%0d exp e=1 r=0",
                     empty1, rdata1);
        end
    endtask

    task automatic test_push_pop;
        op(0, 0, 1, 12'd0);
        op(1, 0, 0, 12'd5);
        op(1, 1, 0, 12'd9);
        nchk++;
        if (count0 !== 4'd1 || rdata0 !== 12'd9 || unf0 !== 1'b0) begin
            nerr++;
            $display("FAIL swap got c=%0d r=%0d u=%b exp 1 9 0",
                     count0, rdata0, unf0);
        end
        op(0, 1, 0, 12'd0);
        op(1, 1, 0, 12'd4);
        nchk++;
        if (count0 !== 4'd1 || rdata0 !== 12'd4 || unf0 !== 1'b1) begin
            nerr++;
            $display("FAIL swap_empty got c=%0d r=%0d u=%b exp 1 4 1",
                     count0, rdata0, unf0);
        end
    endtask

    task automatic test_unf_flush;
        op(0, 0, 1, 12'd0);
        for (int i = 0; i < 9; i++) op(1, 0, 0, 12'd7);
        op(0, 0, 1, 12'd0);
        op(0, 1, 0, 12'd0);
        nchk++;
        if (unf0 !== 1'b1 || count0 !== 4'd0 || ovf0 !== 1'b0) begin
            nerr++;
            $display("FAIL unf got u=%b c=%0d o=%b exp 1 0 0",
                     unf0, count0, ovf0);
        end
        op(1, 0, 0, 12'd2);
        op(0, 1, 0, 12'd0);
        nchk++;
        if (unf0 !== 1'b1) begin
            nerr++;
            $display("FAIL unf_sticky got %b exp 1", unf0);
        end
        op(1, 1, 1, 12'd6);
        nchk++;
        if (count0 !== 4'd0 || unf0 !== 1'b0 || ovf0 !== 1'b0
            || rdata0 !== 12'd0) begin
            nerr++;
            $display("FAIL flush got c=%0d u=%b o=%b r=%0d exp 0 0 0 0",
                     count0, unf0, ovf0, rdata0);
        end
    endtask

    task automatic test_rst_mid;
        op(0, 0, 1, 12'd0);
        op(1, 0, 0, 12'd1);
        op(1, 0, 0, 12'd2);
        push  = 1'b1;
        wdata = 12'd7;
        @(posedge clk);
        #1;
        nchk++;
        if (count0 !== 4'd3 || rdata0 !== 12'd7) begin
            nerr++;
            $display("FAIL burst got c=%0d r=%0d exp 3 7", count0, rdata0);
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        nchk++;
        if (count0 !== 4'd0 || rdata0 !== 12'd0 || empty0 !== 1'b1
            || full0 !== 1'b0) begin
            nerr++;
            $display("FAIL rst_async got c=%0d r=%0d e=%b f=%b exp 0 0 1 0",
                     count0, rdata0, empty0, full0);
        end
        @(posedge clk);
        #1;
        nchk++;
        if (count0 !== 4'd0) begin
            nerr++;
            $display("FAIL rst_held got c=%0d exp 0", count0);
        end
        @(negedge clk);
        rst = 1'b0;
        wdata = 12'd11;
        @(posedge clk);
        #1;
        push = 1'b0;
        nchk++;
        if (count0 !== 4'd1 || rdata0 !== 12'd11) begin
            nerr++;
            $display("FAIL rst_release got c=%0d r=%0d exp 1 11",
                     count0, rdata0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        push  = 1'b0;
        pop   = 1'b0;
        flush = 1'b0;
        wdata = '0;
        test_reset();
        test_basic();
        test_ovf_reject();
        test_ovf_wrap();
        test_push_pop();
        test_unf_flush();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nerr);
        $finish;
    end

endmodule

// File: doc/param_stack.md
PARAM_STACK -- requirements
Module: param_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 12, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 8, entry count; power of two, 2..256.
REQ-003 SHALL have parameter OVF_MODE, default 0: 0 = reject push when full, 1 = overwrite oldest entry when full.
REQ-004 SHALL have port clk  input  1  clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port push  input  1  write wdata as new top.
REQ-007 SHALL have port pop  input  1  discard current top.
REQ-008 SHALL have port flush  input  1  empty the stack and clear error flags.
REQ-009 SHALL have port wdata  input  WIDTH  data to push.
REQ-010 SHALL have port rdata  output  WIDTH  current top entry, combinational from state; 0 when empty.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1)  number of valid entries.
REQ-012 SHALL have ports empty and full  output  1 each  count==0 and count==DEPTH.
REQ-013 SHALL have ports ovf_err and unf_err  output  1 each  sticky overflow and underflow flags.

Function
REQ-014 SHALL keep a storage array plus a top pointer (mod DEPTH) and count register; no state changes on the falling edge.
REQ-015 SHALL give rdata the pushed value from the cycle after the push edge, with zero added latency.
REQ-016 SHALL, on push only and not full: write wdata at top+1, increment top, increment count.
REQ-017 SHALL, on pop only and not empty: decrement top and count; storage contents unchanged.
REQ-018 SHALL, on push and pop together and not empty: overwrite the top entry with wdata, count and top unchanged.
REQ-019 SHALL, on push and pop together when empty: perform the push only and set unf_err.
REQ-020 SHALL, on pop only when empty: leave state unchanged and set unf_err.
REQ-021 SHALL, on push only when full with OVF_MODE=0: leave state unchanged and set ovf_err.
REQ-022 SHALL, on push only when full with OVF_MODE=1: write at top+1 (the oldest slot), advance top, keep count=DEPTH, and set ovf_err.
REQ-023 SHALL, on flush: set count=0, clear ovf_err and unf_err, and ignore push/pop that cycle; flush has highest priority after rst.
REQ-024 SHALL hold ovf_err/unf_err set until rst or flush.
REQ-025 SHALL wrap top pointer arithmetic modulo DEPTH; count never exceeds DEPTH nor goes below 0.

Reset
REQ-026 SHALL, on rst assertion, immediately set count=0, top=DEPTH-1, ovf_err=0, unf_err=0; hence rdata=0, empty=1, full=0.
REQ-027 SHALL NOT reset storage contents.
REQ-028 SHALL, on rst asserted mid-operation, discard any push/pop on the same edge.
REQ-029 SHALL release rst synchronously to clk externally; the block needs no internal synchroniser.

Structure
REQ-030 SHALL place OVF_MODE constants (OVF_REJECT=0, OVF_WRAP=1) in shared package stack_pkg.
REQ-031 SHALL instantiate one sub-module, stack_regfile: a DEPTH x WIDTH array with one synchronous write port and one asynchronous read port.
REQ-032 SHALL keep pointer, count and flag logic in param_stack.

Verification
REQ-033 SHALL be checked for: rst, then push 1,2,3 -> count=3, rdata=3; pop x3 -> rdata 2,1,0, empty=1, unf_err=0.
REQ-034 SHALL be checked for: with OVF_MODE=0, DEPTH=8, push 1..9 -> full=1, count=8, rdata=8, ovf_err=1; then pop x8 -> rdata sequence 7..1, then 0.
REQ-035 SHALL be checked for: with OVF_MODE=1, DEPTH=8, push 1..10 -> count=8, rdata=10, ovf_err=1; pop x8 -> last valid rdata=3, then empty.
REQ-036 SHALL be checked for: push 5, then push+pop with wdata=9 -> count=1, rdata=9; then push+pop when empty (after pop) with wdata=4 -> count=1, rdata=4, unf_err=1.
REQ-037 SHALL be checked for: pop when empty -> unf_err=1, count=0; then flush with push=1 -> count=0, both flags 0.
REQ-038 SHALL be checked for: rst asserted mid-clock during a push burst -> outputs reset immediately; push on the release edge is ignored only if rst is still high at that edge.
